// File: rtl/riscv_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;
  localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            fault;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction ROM port, execute redirect and IF/ID handshake.
interface fetch_stage_if;

  logic [riscv_pkg::XLEN-1:0] imem_addr_o;
  logic [riscv_pkg::ILEN-1:0] imem_rd_i;
  logic                       redirect_i;
  logic [riscv_pkg::XLEN-1:0] redirect_pc_i;
  logic                       id_valid_o;
  logic                       id_ready_i;
  logic [riscv_pkg::ILEN-1:0] id_instr_o;
  logic [riscv_pkg::XLEN-1:0] id_pc_o;
  logic [riscv_pkg::XLEN-1:0] id_pc_plus4_o;
  logic                       id_fault_o;
  logic                       halted_o;

  modport master (
    output imem_addr_o,
    input  imem_rd_i,
    input  redirect_i,
    input  redirect_pc_i,
    output id_valid_o,
    input  id_ready_i,
    output id_instr_o,
    output id_pc_o,
    output id_pc_plus4_o,
    output id_fault_o,
    output halted_o
  );

  modport slave (
    input  imem_addr_o,
    output imem_rd_i,
    output redirect_i,
    output redirect_pc_i,
    input  id_valid_o,
    output id_ready_i,
    input  id_instr_o,
    input  id_pc_o,
    input  id_pc_plus4_o,
    input  id_fault_o,
    input  halted_o
  );

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID valid/ready pipeline register with flush; payload only moves when a token is loaded.
module if_id_reg
  import riscv_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  input  logic   in_valid,
  input  if_id_t in_data,
  input  logic   ready,
  output logic   out_valid,
  output if_id_t out_data
);

  logic advance;

  assign advance = !out_valid || ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '{instr: NOP_INSTR, pc: '0, pc_plus4: '0, fault: 1'b0};
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (advance) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, ROM address, legality check and RUN/HALT control.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     IMEM_BYTES = 52
) (
  input logic           clk,
  input logic           rst_n,
  fetch_stage_if.master bus
);

  localparam int unsigned AW      = XLEN + 1;
  localparam logic [0:0]  ST_RUN  = 1'(RUN);
  localparam logic [0:0]  ST_HALT = 1'(HALT);

  logic [0:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [AW-1:0]   pc_last_byte;
  logic            pc_legal;
  logic            advance;
  logic            flush;
  logic            fetch_valid;
  if_id_t          fetch_data;
  logic            id_valid;
  if_id_t          id_data;

  assign advance = !id_valid || bus.id_ready_i;

  // Extra bit keeps a PC near the top of the address space from wrapping past the bound.
  assign pc_last_byte = {1'b0, pc_q} + AW'(3);
  assign pc_legal     = (pc_q[1:0] == 2'b00) && (pc_last_byte < AW'(IMEM_BYTES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Priority: redirect, then fault/fetch on advance, otherwise hold.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    flush       = 1'b0;
    fetch_valid = 1'b0;
    fetch_data  = '{instr: NOP_INSTR, pc: pc_q, pc_plus4: pc_q + XLEN'(4), fault: 1'b0};

    if (bus.redirect_i) begin
      pc_d    = bus.redirect_pc_i;
      state_d = ST_RUN;
      flush   = 1'b1;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (advance) begin
            fetch_valid = 1'b1;
            if (pc_legal) begin
              fetch_data.instr = bus.imem_rd_i;
              pc_d             = pc_q + XLEN'(4);
            end else begin
              fetch_data.fault = 1'b1;
              state_d          = ST_HALT;
            end
          end
        end
        default: begin
          // HALT: nothing new is loaded, so the fault token drains and valid drops.
          fetch_valid = 1'b0;
        end
      endcase
    end
  end

  if_id_reg u_if_id_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (fetch_valid),
    .in_data   (fetch_data),
    .ready     (bus.id_ready_i),
    .out_valid (id_valid),
    .out_data  (id_data)
  );

  assign bus.imem_addr_o   = pc_q;
  assign bus.halted_o      = (state_q == ST_HALT);
  assign bus.id_valid_o    = id_valid;
  assign bus.id_instr_o    = id_data.instr;
  assign bus.id_pc_o       = id_data.pc;
  assign bus.id_pc_plus4_o = id_data.pc_plus4;
  assign bus.id_fault_o    = id_data.fault;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random stalls/redirects vs a reference model.
module tb_fetch_stage;

  localparam int unsigned ROM_BYTES = 52;
  localparam int unsigned ROM_WORDS = 13;
  localparam logic [31:0] NOP       = 32'h0000_0013;

  logic clk;
  logic rst_n;
  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(32'h0000_0000), .IMEM_BYTES(ROM_BYTES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] rom [ROM_WORDS];

  // Combinational ROM: junk outside the loaded range so illegal fetches cannot pass by accident.
  always_comb begin
    if (bus.imem_addr_o < 32'(ROM_BYTES))
      bus.imem_rd_i = rom[bus.imem_addr_o[5:2]];
    else
      bus.imem_rd_i = 32'hDEAD_BEEF;
  end

  int n_checks;
  int n_fail;

  // Reference model: architectural view of pc, halt flag and the IF/ID slot.
  logic [31:0] m_pc;
  logic        m_halt;
  logic        m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;
  logic [31:0] m_p4;
  logic        m_fault;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'h0;
    m_halt  = 1'b0;
    m_valid = 1'b0;
    m_instr = NOP;
    m_ipc   = 32'h0;
    m_p4    = 32'h0;
    m_fault = 1'b0;
  endtask

  function automatic bit legal(input logic [31:0] pc);
    longint unsigned last_byte;
    last_byte = longint'(pc) + 3;
    return (pc % 4 == 0) && (last_byte < longint'(ROM_BYTES));
  endfunction

  task automatic model_clock(input logic rd, input logic [31:0] rpc, input logic rdy);
    bit slot_free;
    slot_free = !m_valid || rdy;
    if (rd) begin
      m_pc    = rpc;
      m_valid = 1'b0;
      m_halt  = 1'b0;
    end else if (slot_free && !m_halt) begin
      m_valid = 1'b1;
      m_ipc   = m_pc;
      m_p4    = m_pc + 32'd4;
      if (legal(m_pc)) begin
        m_instr = rom[m_pc / 4];
        m_fault = 1'b0;
        m_pc    = m_pc + 32'd4;
      end else begin
        m_instr = NOP;
        m_fault = 1'b1;
        m_halt  = 1'b1;
      end
    end else if (slot_free) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("halted", 32'(bus.halted_o), 32'(m_halt));
    chk("imem_addr", bus.imem_addr_o, m_pc);
    chk("id_valid", 32'(bus.id_valid_o), 32'(m_valid));
    if (m_valid) begin
      chk("id_instr", bus.id_instr_o, m_instr);
      chk("id_pc", bus.id_pc_o, m_ipc);
      chk("id_pc_plus4", bus.id_pc_plus4_o, m_p4);
      chk("id_fault", 32'(bus.id_fault_o), 32'(m_fault));
    end
  endtask

  // One clock: drive at negedge, let the edge happen, update model, check at next negedge.
  task automatic step(input logic rd, input logic [31:0] rpc, input logic rdy);
    bus.redirect_i    = rd;
    bus.redirect_pc_i = rpc;
    bus.id_ready_i    = rdy;
    @(posedge clk);
    model_clock(rd, rpc, rdy);
    @(negedge clk);
    check_all();
  endtask

  initial begin
    logic [31:0] tgt;
    logic        rd;
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < int'(ROM_WORDS); i++) rom[i] = $urandom;
    rom[0] = 32'h0050_0093;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.id_ready_i    = 1'b1;
    rst_n = 1'b0;
    model_reset();

    // Reset state
    #12;
    chk("rst_valid", 32'(bus.id_valid_o), 32'h0);
    chk("rst_instr", bus.id_instr_o, NOP);
    chk("rst_pc", bus.id_pc_o, 32'h0);
    chk("rst_pc_plus4", bus.id_pc_plus4_o, 32'h0);
    chk("rst_fault", 32'(bus.id_fault_o), 32'h0);
    chk("rst_halted", 32'(bus.halted_o), 32'h0);
    chk("rst_addr", bus.imem_addr_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming fetch with a 3-cycle decode stall while pc 4 is presented
    step(1'b0, 32'h0, 1'b1);
    chk("seq_pc0", bus.id_pc_o, 32'h0);
    chk("seq_instr0", bus.id_instr_o, 32'h0050_0093);
    step(1'b0, 32'h0, 1'b1);
    chk("seq_pc4", bus.id_pc_o, 32'h4);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b0);
      chk("stall_pc", bus.id_pc_o, 32'h4);
      chk("stall_instr", bus.id_instr_o, rom[1]);
    end
    step(1'b0, 32'h0, 1'b1);
    chk("seq_pc8", bus.id_pc_o, 32'h8);
    step(1'b0, 32'h0, 1'b1);
    chk("seq_pcC", bus.id_pc_o, 32'hC);
    chk("seq_instrC", bus.id_instr_o, rom[3]);

    // Redirect flushes a valid slot even with ready high
    step(1'b1, 32'h20, 1'b1);
    chk("redir_flush", 32'(bus.id_valid_o), 32'h0);
    step(1'b0, 32'h0, 1'b1);
    chk("redir_pc", bus.id_pc_o, 32'h20);
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);
    chk("last_legal_pc", bus.id_pc_o, 32'h30);

    // Falling off the end of the ROM: exactly one fault token, then HALT
    step(1'b0, 32'h0, 1'b1);
    chk("oor_fault", 32'(bus.id_fault_o), 32'h1);
    chk("oor_instr", bus.id_instr_o, NOP);
    chk("oor_pc", bus.id_pc_o, 32'h34);
    chk("oor_halted", 32'(bus.halted_o), 32'h1);
    step(1'b0, 32'h0, 1'b1);
    chk("halt_drained", 32'(bus.id_valid_o), 32'h0);
    step(1'b0, 32'h0, 1'b1);

    // Misaligned redirect faults, aligned redirect resumes
    step(1'b1, 32'h6, 1'b1);
    step(1'b0, 32'h0, 1'b1);
    chk("mis_fault", 32'(bus.id_fault_o), 32'h1);
    chk("mis_pc", bus.id_pc_o, 32'h6);
    chk("mis_halted", 32'(bus.halted_o), 32'h1);
    step(1'b1, 32'h0, 1'b1);
    chk("resume_run", 32'(bus.halted_o), 32'h0);
    step(1'b0, 32'h0, 1'b1);
    chk("resume_pc", bus.id_pc_o, 32'h0);
    chk("resume_fault", 32'(bus.id_fault_o), 32'h0);

    // Random stalls and redirects, with an asynchronous reset in the middle
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(bus.id_valid_o), 32'h0);
        chk("async_rst_addr", bus.imem_addr_o, 32'h0);
        chk("async_rst_halted", 32'(bus.halted_o), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 32'h0, 1'b1);
        chk("post_rst_pc", bus.id_pc_o, 32'h0);
      end
      rd = ($urandom_range(0, 99) < (m_halt ? 30 : 5));
      case ($urandom_range(0, 3))
        0:       tgt = {26'h0, 4'($urandom_range(0, 12)), 2'b00};
        1:       tgt = 32'($urandom_range(0, 60));
        2:       tgt = 32'hFFFF_FFFC;
        default: tgt = $urandom;
      endcase
      step(rd, tgt, ($urandom_range(0, 99) < 70));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
